nco_sym_sched: RTL and testbench

- Symbol scheduler for the NCO phase-increment input.
- Accepts an M-ary symbol stream through a valid/ready handshake and maps each symbol to a phase increment from a programmable table.
- Holds that increment for a programmable number of clken samples, then reverts to an idle carrier increment.
- Produces a sample-valid flag delayed to line up with the NCO output pipeline. It sits between the symbol source (spreader/mapper) and the NCO phi_inc_i input, and shares that NCO's clk/clken.

---
 rtl/nco_sym_sched.sv | 158 +++++++++++++++
 tb/tb_nco_sym_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/nco_sym_sched.sv
// nco_sym_sched: maps a valid/ready symbol stream onto NCO phase increments.
// Each accepted symbol is held for a programmable number of clken samples.
// The scheduler then falls back to an idle carrier increment and drains the
// NCO pipeline. tx_valid_o is the RUN flag delayed by the NCO latency.
// The config address map reserves 0..3 for table entries, so SW is at most 2.
// The delay line needs LAT >= 2.
module nco_sym_sched #(
  parameter int APR = 32,
  parameter int SW  = 2,
  parameter int CW  = 16,
  parameter int LAT = 9
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic           cfg_we,
  input  logic [2:0]     cfg_addr,
  input  logic [APR-1:0] cfg_wdata,
  input  logic           sym_valid,
  input  logic [SW-1:0]  sym_data,
  output logic           sym_ready,
  output logic [APR-1:0] phi_inc_o,
  output logic           tx_valid_o,
  output logic           busy_o,
  output logic           underrun_o
);

  localparam int DEPTH = 2 ** SW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  logic [APR-1:0] tbl_q [DEPTH];
  logic [APR-1:0] tbl_d [DEPTH];
  logic [CW-1:0]  sps_q, sps_d;
  logic [APR-1:0] idle_inc_q, idle_inc_d;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  dcnt_q, dcnt_d;
  logic [CW-1:0]  sps_act_q, sps_act_d;
  logic [APR-1:0] phi_inc_q, phi_inc_d;
  logic           underrun_q, underrun_d;
  logic [LAT-1:0] dly_q, dly_d;

  logic last_sample;
  logic xfer;
  logic set_underrun;
  logic clr_underrun;

  // Handshake: ready on the final sample of a symbol, or whenever not running.
  always_comb begin
    last_sample = (state_q == RUN) && (cnt_q == sps_act_q - CW'(1));
    sym_ready   = clken && ((state_q == IDLE) || (state_q == DRAIN) || last_sample);
    xfer        = sym_valid && sym_ready;
  end

  // Config register file; independent of clken, visible from the next cycle.
  always_comb begin
    tbl_d        = tbl_q;
    sps_d        = sps_q;
    idle_inc_d   = idle_inc_q;
    clr_underrun = 1'b0;
    if (cfg_we) begin
      if (int'(cfg_addr) < DEPTH) begin
        tbl_d[cfg_addr[SW-1:0]] = cfg_wdata;
      end else if (cfg_addr == 3'd4) begin
        sps_d = cfg_wdata[CW-1:0];
      end else if (cfg_addr == 3'd5) begin
        idle_inc_d = cfg_wdata;
      end else if (cfg_addr == 3'd6) begin
        clr_underrun = 1'b1;
      end
    end
  end

  // Symbol sequencing; everything holds when clken is low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dcnt_d       = dcnt_q;
    sps_act_d    = sps_act_q;
    phi_inc_d    = phi_inc_q;
    dly_d        = dly_q;
    set_underrun = 1'b0;
    if (clken) begin
      dly_d = {dly_q[LAT-2:0], (state_q == RUN)};
      if (xfer) begin
        // Table and sps are sampled only here, so config writes never split a symbol.
        phi_inc_d = tbl_q[sym_data];
        sps_act_d = (sps_q == '0) ? CW'(1) : sps_q;
        cnt_d     = '0;
        state_d   = RUN;
      end else begin
        case (state_q)
          IDLE: phi_inc_d = idle_inc_q;
          RUN: begin
            if (last_sample) begin
              phi_inc_d    = idle_inc_q;
              set_underrun = 1'b1;
              dcnt_d       = '0;
              state_d      = DRAIN;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          DRAIN: begin
            dcnt_d = dcnt_q + CW'(1);
            if (dcnt_q == CW'(LAT - 1)) begin
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
    // A new underrun outranks a simultaneous clear.
    underrun_d = set_underrun ? 1'b1 : (clr_underrun ? 1'b0 : underrun_q);
  end

  // State and config registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
      sps_q      <= CW'(1);
      idle_inc_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      sps_act_q  <= CW'(1);
      phi_inc_q  <= '0;
      underrun_q <= 1'b0;
      dly_q      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
      sps_q      <= sps_d;
      idle_inc_q <= idle_inc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      sps_act_q  <= sps_act_d;
      phi_inc_q  <= phi_inc_d;
      underrun_q <= underrun_d;
      dly_q      <= dly_d;
    end
  end

  // Output mapping.
  always_comb begin
    phi_inc_o  = phi_inc_q;
    tx_valid_o = dly_q[LAT-1];
    busy_o     = (state_q != IDLE);
    underrun_o = underrun_q;
  end

endmodule

// File: tb/tb_nco_sym_sched.sv
// Directed testbench for nco_sym_sched with hand-computed expectations.
module tb_nco_sym_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym_data = 2'd0;
  logic        sym_ready;
  logic [31:0] phi_inc_o;
  logic        tx_valid_o;
  logic        busy_o;
  logic        underrun_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] IDLE_INC = 32'h0080_0000;

  nco_sym_sched dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clken      (clken),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .sym_ready  (sym_ready),
    .phi_inc_o  (phi_inc_o),
    .tx_valid_o (tx_valid_o),
    .busy_o     (busy_o),
    .underrun_o (underrun_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clken = 1'b1;
    tick(); tick();
    checks++; if (phi_inc_o !== 32'h0) begin errors++; $display("FAIL reset_phi: got %h expected %h", phi_inc_o, 32'h0); end
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_tx: got %b expected 0", tx_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun_o); end
    checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", sym_ready); end
    reset_n = 1'b1;
    tick();
    cfg_write(3'd0, 32'h0100_0000);
    cfg_write(3'd1, 32'h0200_0000);
    cfg_write(3'd2, 32'h0300_0000);
    cfg_write(3'd3, 32'h0400_0000);
    cfg_write(3'd4, 32'd4);
    cfg_write(3'd7, 32'hFFFF_FFFF);
    cfg_write(3'd5, IDLE_INC);
    // idle_inc is only visible to the refresh one cycle after the write
    checks++; if (phi_inc_o !== 32'h0) begin errors++; $display("FAIL cfg_latency_phi: got %h expected %h", phi_inc_o, 32'h0); end
    tick();
    checks++; if (phi_inc_o !== IDLE_INC) begin errors++; $display("FAIL idle_phi: got %h expected %h", phi_inc_o, IDLE_INC); end
    checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", sym_ready); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_burst();
    logic [31:0] vals [3];
    logic [1:0]  syms [3];
    logic [31:0] exp_phi;
    vals[0] = 32'h0300_0000; vals[1] = 32'h0100_0000; vals[2] = 32'h0400_0000;
    syms[0] = 2'd2; syms[1] = 2'd0; syms[2] = 2'd3;
    sym_valid = 1'b1; sym_data = syms[0];
    for (int j = 0; j <= 22; j++) begin
      tick();
      exp_phi = (j < 12) ? vals[j / 4] : IDLE_INC;
      checks++; if (phi_inc_o !== exp_phi) begin errors++; $display("FAIL burst_phi[%0d]: got %h expected %h", j, phi_inc_o, exp_phi); end
      checks++; if (sym_ready !== ((j >= 11) || (j % 4 == 3))) begin errors++; $display("FAIL burst_ready[%0d]: got %b expected %b", j, sym_ready, ((j >= 11) || (j % 4 == 3))); end
      checks++; if (tx_valid_o !== ((j >= 9) && (j <= 20))) begin errors++; $display("FAIL burst_tx[%0d]: got %b expected %b", j, tx_valid_o, ((j >= 9) && (j <= 20))); end
      checks++; if (busy_o !== (j <= 20)) begin errors++; $display("FAIL burst_busy[%0d]: got %b expected %b", j, busy_o, (j <= 20)); end
      checks++; if (underrun_o !== (j >= 12)) begin errors++; $display("FAIL burst_underrun[%0d]: got %b expected %b", j, underrun_o, (j >= 12)); end
      if ((j % 4 == 3) && (j < 11)) sym_data = syms[j / 4 + 1];
      if (j == 11) sym_valid = 1'b0;
    end
  endtask

  task automatic test_underrun();
    logic [31:0] exp_phi;
    cfg_write(3'd6, 32'd0);
    checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL underrun_clear0: got %b expected 0", underrun_o); end
    sym_valid = 1'b1; sym_data = 2'd1;
    for (int j = 0; j <= 13; j++) begin
      tick();
      exp_phi = (j < 4) ? 32'h0200_0000 : IDLE_INC;
      checks++; if (phi_inc_o !== exp_phi) begin errors++; $display("FAIL single_phi[%0d]: got %h expected %h", j, phi_inc_o, exp_phi); end
      checks++; if (underrun_o !== (j >= 4)) begin errors++; $display("FAIL single_underrun[%0d]: got %b expected %b", j, underrun_o, (j >= 4)); end
      checks++; if (busy_o !== (j <= 12)) begin errors++; $display("FAIL single_busy[%0d]: got %b expected %b", j, busy_o, (j <= 12)); end
      if (j == 0) sym_valid = 1'b0;
      // clear requested on the same edge the underrun sets: set must win
      if (j == 3) begin cfg_we = 1'b1; cfg_addr = 3'd6; end
      if (j == 4) cfg_we = 1'b0;
    end
    cfg_write(3'd6, 32'd0);
    checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b expected 0", underrun_o); end
  endtask

  task automatic test_clken();
    logic [31:0] exp_phi;
    logic        exp_rdy;
    cfg_write(3'd4, 32'd3);
    clken = 1'b1; sym_valid = 1'b1; sym_data = 2'd3;
    for (int k = 0; k <= 19; k++) begin
      tick();
      exp_phi = (k < 6) ? 32'h0400_0000 : ((k < 12) ? 32'h0300_0000 : IDLE_INC);
      checks++; if (phi_inc_o !== exp_phi) begin errors++; $display("FAIL clken_phi[%0d]: got %h expected %h", k, phi_inc_o, exp_phi); end
      checks++; if (tx_valid_o !== (k >= 18)) begin errors++; $display("FAIL clken_tx[%0d]: got %b expected %b", k, tx_valid_o, (k >= 18)); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL clken_busy[%0d]: got %b expected 1", k, busy_o); end
      if (k == 0) sym_data = 2'd2;
      if (k == 11) sym_valid = 1'b0;
      clken = (k % 2 == 1);
      #1;
      exp_rdy = clken && ((k >= 12) || (k % 6 == 5));
      checks++; if (sym_ready !== exp_rdy) begin errors++; $display("FAIL clken_ready[%0d]: got %b expected %b", k, sym_ready, exp_rdy); end
    end
    clken = 1'b1;
    repeat (30) tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL clken_drain_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_midwrite();
    logic [31:0] exp_phi;
    cfg_write(3'd4, 32'd4);
    sym_valid = 1'b1; sym_data = 2'd0;
    for (int k = 0; k <= 9; k++) begin
      tick();
      exp_phi = (k < 4) ? 32'h0100_0000 : ((k < 6) ? 32'h0A00_0000 : IDLE_INC);
      checks++; if (phi_inc_o !== exp_phi) begin errors++; $display("FAIL midwr_phi[%0d]: got %h expected %h", k, phi_inc_o, exp_phi); end
      checks++; if (sym_ready !== ((k == 3) || (k == 5) || (k >= 6))) begin errors++; $display("FAIL midwr_ready[%0d]: got %b expected %b", k, sym_ready, ((k == 3) || (k == 5) || (k >= 6))); end
      if (k == 0) begin cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'h0A00_0000; end
      if (k == 1) begin cfg_addr = 3'd4; cfg_wdata = 32'd2; end
      if (k == 2) cfg_we = 1'b0;
      if (k == 5) sym_valid = 1'b0;
    end
    repeat (12) tick();
  endtask

  task automatic test_reset_mid();
    cfg_write(3'd4, 32'd4);
    sym_valid = 1'b1; sym_data = 2'd1;
    for (int k = 0; k <= 10; k++) tick();
    checks++; if (tx_valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset_tx: got %b expected 1", tx_valid_o); end
    checks++; if (underrun_o !== 1'b1) begin errors++; $display("FAIL pre_reset_underrun: got %b expected 1", underrun_o); end
    reset_n = 1'b0;
    #1;
    checks++; if (phi_inc_o !== 32'h0) begin errors++; $display("FAIL async_phi: got %h expected %h", phi_inc_o, 32'h0); end
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL async_tx: got %b expected 0", tx_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", busy_o); end
    checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL async_underrun: got %b expected 0", underrun_o); end
    sym_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (phi_inc_o !== 32'h0) begin errors++; $display("FAIL post_reset_idle_phi: got %h expected %h", phi_inc_o, 32'h0); end
    sym_valid = 1'b1; sym_data = 2'd1;
    tick();
    sym_valid = 1'b0;
    checks++; if (phi_inc_o !== 32'h0) begin errors++; $display("FAIL post_reset_tbl: got %h expected %h", phi_inc_o, 32'h0); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL post_reset_busy: got %b expected 1", busy_o); end
    checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL post_reset_sps1_ready: got %b expected 1", sym_ready); end
    tick();
    checks++; if (underrun_o !== 1'b1) begin errors++; $display("FAIL post_reset_sps1_underrun: got %b expected 1", underrun_o); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_underrun();
    test_clken();
    test_midwrite();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
